pe_result_drain: RTL and testbench
==================================

# pe_result_drain

Receive-side companion to the skewed activation/weight feeder of `pe_8x8_cluster`. It watches the cluster's per-row `output_dones`, captures each finished row of accumulator results from the flat `results` bus, and streams them out one PE value per transfer over a valid/ready handshake. Rows are drained in ascending row order, and the end of a full 8-row frame is flagged. It sits between `pe_8x8_cluster` and the downstream softmax/writeback logic.

## Interface
- `ROWS`, 8, number of PE rows (one done bit per row)
- `COLS`, 8, PEs per row
- `RES_W`, 36, width of one PE result; `results` width = `ROWS*COLS*RES_W` (2304 at defaults)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  global enable; low freezes all state
- `results`  in  `ROWS*COLS*RES_W`  PE(r,c) at bits `[(r*COLS+c)*RES_W +: RES_W]`
- `dones`  in  `ROWS`  per-row done from cluster `output_dones`; level, rising edge = row complete
- `out_data`  out  `RES_W`  current result value
- `out_row`  out  3  row index of `out_data`
- `out_col`  out  3  column index of `out_data`
- `out_valid`  out  1  `out_data`/`out_row`/`out_col` valid
- `out_ready`  in  1  downstream accepts
- `out_last`  out  1  high with the final beat of the frame (row `ROWS-1`, col `COLS-1`)
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted
- `busy`  out  1  any row captured and not yet fully drained
- `overflow`  out  1  sticky; set when a row's done rises while that row is still pending

## Operation
- Edge detect: `dones_q` is registered. `rise = dones & ~dones_q`, evaluated only when `en`=1.
- Capture: on a clock edge with `rise[r]`=1 and `pending[r]`=0, the 8 results of row r are copied into `row_buf[r]` and `pending[r]` is set.
- A rise on a pending row sets `overflow`. The buffer is not overwritten.
- FSM states:
  - IDLE: `out_valid`=0. Go to SEND when `pending[cur_row]`=1.
  - SEND: present `row_buf[cur_row][cur_col]`. Stay in SEND while the beat is not accepted.
  - On acceptance, `cur_col` increments. At `cur_col`=COLS-1, clear `pending[cur_row]`, set `cur_col`=0, and increment `cur_row`.
  - At `cur_row`=ROWS-1, set `cur_row`=0 and go to FDONE. Otherwise go to SEND if the next row is pending, else IDLE.
  - FDONE: pulse `frame_done` for one cycle, then go to IDLE.
- Row order is strict ascending. A later row that is captured early waits for the earlier rows to drain.
- A capture and the drain clear of the same row on the same edge resolve as: clear first, then capture. The new row is accepted and `overflow` is not set.
- `en`=0: no capture, no FSM advance, `dones_q` holds, and all outputs hold their values. The handshake is frozen, and `out_ready` is ignored.
- Reset (async, mid-operation included) clears the following:
  - `pending`, `dones_q`, `cur_row`, `cur_col` to 0
  - state to IDLE
  - `out_valid`, `out_last`, `frame_done`, `busy`, `overflow` to 0
  - `out_data`, `out_row`, `out_col` to 0
- `row_buf` contents are not reset.

## Timing
- All outputs are registered.
- Latency: done rise sampled at edge N gives capture at edge N, `out_valid`=1 after edge N+1 (if the row is next in order and the FSM is idle).
- Handshake: a transfer occurs on an edge with `out_valid`&&`out_ready`. While `out_valid`&&!`out_ready`, the data and indices are held stable.
- Throughput: one beat per cycle with `out_ready` held high. A full row takes 8 cycles; a frame takes 64 beats.
- Between rows there are no bubbles if the next row is already pending.
- After the 64th acceptance, the FSM spends one cycle in FDONE with `frame_done`=1.

## Configuration
- `PE_DRAIN_SAT_EN` defined: each value is saturated to the signed 16-bit range [-32768, 32767] and sign-extended to `RES_W` before registering onto `out_data`.
- Not defined: the raw `RES_W`-bit value is passed through unchanged.
- Timing is identical in both cases.

## Structure
- Package `pe_drain_pkg` holds:
  - `ROWS`, `COLS`, `RES_W` defaults
  - the state encoding (IDLE, SEND, FDONE)
  - the result-slice index helper
- Sub-module `pe_drain_sat` is the combinational saturator. It is instantiated only under `PE_DRAIN_SAT_EN`.

## Test plan
- **Ordered frame:** drive rows 0..7 done one cycle apart with PE(r,c)=r*8+c, `out_ready`=1. Expect:
  - 64 beats with values 0..63 in order
  - `out_last` on value 63
  - `frame_done` one cycle later
  - `overflow`=0
- **Backpressure:** toggle `out_ready` 1/0 each cycle during row 0. Expect:
  - data held while stalled
  - 8 beats with no loss or duplication
- **Out-of-order arrival:** raise done for row 3 before row 0. Expect:
  - no output until row 0 is captured
  - drained order 0,1,2,3
- **Overflow:** re-pulse `dones[0]` while row 0 is pending and `out_ready`=0. Expect:
  - `overflow`=1 (sticky)
  - the original row 0 data is still output
- **Mid-drain reset:** assert `rst_n`=0 after beat 5. Expect all outputs 0 immediately. A new frame after reset drains correctly.
- **Saturation:** with `PE_DRAIN_SAT_EN` defined, PE(0,0)=40000 outputs 32767 and PE(0,1)=-40000 outputs -32768, sign-extended to 36 bits. With the macro undefined, both raw values pass through.

Source files
------------

// File: rtl/pe_drain_pkg.sv
`default_nettype none
// pe_drain_pkg -- sizing defaults, drain FSM encoding and result-slice helper (rev 1.0)
package pe_drain_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int RES_W = 36;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_FDONE = 2'd2;

  localparam int SAT_HI = 32767;
  localparam int SAT_LO = -32768;

  // LSB of PE(row,col) inside the flat cluster results bus
  function automatic int res_lsb(input int row, input int col, input int cols, input int w);
    return (row * cols + col) * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_drain_sat.sv
`default_nettype none
// pe_drain_sat -- clamps a signed result to the 16-bit range, sign-extended to W bits (rev 1.0)
module pe_drain_sat #(
  parameter int W = 36
) (
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);
  import pe_drain_pkg::*;

  localparam logic signed [W-1:0] C_HI = W'(SAT_HI);
  localparam logic signed [W-1:0] C_LO = W'(SAT_LO);

  always_comb begin
    if ($signed(d_i) > C_HI)      d_o = C_HI;
    else if ($signed(d_i) < C_LO) d_o = C_LO;
    else                          d_o = d_i;
  end

endmodule
`default_nettype wire

// File: rtl/pe_result_drain.sv
`default_nettype none
// pe_result_drain -- captures finished PE rows and streams them out in row order (rev 1.0)
// Define PE_DRAIN_SAT_EN to saturate each value to signed 16 bits before it is registered.
module pe_result_drain #(
  parameter int ROWS  = pe_drain_pkg::ROWS,
  parameter int COLS  = pe_drain_pkg::COLS,
  parameter int RES_W = pe_drain_pkg::RES_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [ROWS*COLS*RES_W-1:0]  results_i,
  input  logic [ROWS-1:0]             dones_i,
  output logic [RES_W-1:0]            out_data_o,
  output logic [2:0]                  out_row_o,
  output logic [2:0]                  out_col_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        out_last_o,
  output logic                        frame_done_o,
  output logic                        busy_o,
  output logic                        overflow_o
);
  import pe_drain_pkg::*;

  logic [ROWS-1:0]  dones_q, pending_q, pending_d, rise, clr, cap;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cur_row_q, cur_row_d, cur_col_q, cur_col_d, sel_row, sel_col;
  logic             load, valid_d, last_d, frame_done_d, overflow_d;
  logic [RES_W-1:0] row_buf_q [ROWS][COLS];
  logic [RES_W-1:0] w_raw, w_val;
  logic [RES_W-1:0] out_data_q;
  logic [2:0]       out_row_q, out_col_q;
  logic             out_valid_q, out_last_q, frame_done_q, busy_q, overflow_q;

  assign rise  = dones_i & ~dones_q;
  assign w_raw = row_buf_q[sel_row][sel_col];

`ifdef PE_DRAIN_SAT_EN
  pe_drain_sat #(.W(RES_W)) u_sat (.d_i(w_raw), .d_o(w_val));
`else
  assign w_val = w_raw;
`endif

  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    sel_row      = cur_row_q;
    sel_col      = cur_col_q;
    load         = 1'b0;
    valid_d      = out_valid_q;
    frame_done_d = 1'b0;
    clr          = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q[cur_row_q]) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_ready_i) begin
          if (cur_col_q != 3'(COLS-1)) begin
            cur_col_d = cur_col_q + 3'd1;
            sel_col   = cur_col_d;
            load      = 1'b1;
          end else begin
            clr[cur_row_q] = 1'b1;
            cur_col_d      = '0;
            if (cur_row_q == 3'(ROWS-1)) begin
              cur_row_d    = '0;
              state_d      = ST_FDONE;
              valid_d      = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              cur_row_d = cur_row_q + 3'd1;
              // Back-to-back rows: present the next row's first beat without a bubble
              if (pending_q[cur_row_d]) begin
                sel_row = cur_row_d;
                sel_col = '0;
                load    = 1'b1;
              end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
              end
            end
          end
        end
      end
      ST_FDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (load) valid_d = 1'b1;
  end

  assign last_d = (sel_row == 3'(ROWS-1)) && (sel_col == 3'(COLS-1));

  // Drain clear takes effect before capture, so a same-edge re-fill of a draining row is legal
  assign cap        = rise & (~pending_q | clr);
  assign pending_d  = (pending_q & ~clr) | cap;
  assign overflow_d = overflow_q | (|(rise & pending_q & ~clr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dones_q      <= '0;
      pending_q    <= '0;
      state_q      <= ST_IDLE;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (en_i) begin
      dones_q      <= dones_i;
      pending_q    <= pending_d;
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      out_valid_q  <= valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= |pending_d;
      overflow_q   <= overflow_d;
      if (load) begin
        out_data_q <= w_val;
        out_row_q  <= sel_row;
        out_col_q  <= sel_col;
        out_last_q <= last_d;
      end else if (!valid_d) begin
        out_last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cap[r]) begin
          for (int c = 0; c < COLS; c++) begin
            row_buf_q[r][c] <= results_i[res_lsb(r, c, COLS, RES_W) +: RES_W];
          end
        end
      end
    end
  end

  assign out_data_o   = out_data_q;
  assign out_row_o    = out_row_q;
  assign out_col_o    = out_col_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_result_drain.sv
`default_nettype none
// tb_pe_result_drain -- scoreboard bench for pe_result_drain (rev 1.0)
module tb_pe_result_drain;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int RES_W = 36;
  localparam logic signed [RES_W-1:0] C_SMAX = 36'sd32767;
  localparam logic signed [RES_W-1:0] C_SMIN = -36'sd32768;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       en = 1'b1;
  logic [ROWS-1:0]            dones = '0;
  logic                       out_ready = 1'b1;
  logic [ROWS*COLS*RES_W-1:0] results;
  logic [RES_W-1:0]           out_data;
  logic [2:0]                 out_row, out_col;
  logic                       out_valid, out_last, frame_done, busy, overflow;
  logic [RES_W-1:0]           pe_val [ROWS][COLS];

  always #5 clk = ~clk;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign results[(r*COLS+c)*RES_W +: RES_W] = pe_val[r][c];
    end
  end

  pe_result_drain dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .results_i(results), .dones_i(dones),
    .out_data_o(out_data), .out_row_o(out_row), .out_col_o(out_col),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .frame_done_o(frame_done), .busy_o(busy), .overflow_o(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input logic [RES_W-1:0] v);
`ifdef PE_DRAIN_SAT_EN
    if ($signed(v) > C_SMAX) return C_SMAX;
    if ($signed(v) < C_SMIN) return C_SMIN;
`endif
    return v;
  endfunction

  // Scoreboard item: {last, row, col, data}
  logic [42:0] sb [$];
  bit          hold_v = 1'b0;
  logic [41:0] held;
  bit          exp_fd = 1'b0;
  int          nbeats = 0;
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
      exp_fd = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (hold_v) chk("hold_stable", {out_row, out_col, out_data}, held);
      if (exp_fd) begin
        chk("frame_done_pulse", frame_done, 1);
        exp_fd = 1'b0;
      end
      if (out_valid && out_ready && en) begin
        if (sb.size() == 0) chk("extra_beat", {out_last, out_row, out_col, out_data}, 43'h7ff_ffff_ffff);
        else chk("beat", {out_last, out_row, out_col, out_data}, sb.pop_front());
        nbeats++;
        if (out_last) exp_fd = 1'b1;
        hold_v = 1'b0;
      end else begin
        hold_v = out_valid;
        held   = {out_row, out_col, out_data};
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    dones     = '0;
    en        = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    #1;
    chk("rst_data", {out_data, out_row, out_col}, 0);
    chk("rst_flags", {out_valid, out_last, frame_done, busy, overflow}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < COLS; c++)
      sb.push_back({1'((r == ROWS-1) && (c == COLS-1)), 3'(r), 3'(c), model(pe_val[r][c])});
  endtask

  task automatic randomize_vals();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pe_val[r][c] = {4'($urandom), 32'($urandom)};
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic run_ordered_frame();
    int fd0;
    fd0 = fd_cnt;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pe_val[r][c] = 36'(r*COLS + c);
    for (int r = 0; r < ROWS; r++) push_row(r);
    out_ready = 1'b1;
    dones[0]  = 1'b1;
    step(1);
    chk("lat_capture_busy", busy, 1);
    chk("lat_capture_valid", out_valid, 0);
    dones[1] = 1'b1;
    step(1);
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_data", out_data, 0);
    for (int r = 2; r < ROWS; r++) begin
      dones[r] = 1'b1;
      step(1);
    end
    wait_empty("frame_drained", 200);
    step(3);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("frame_end_state", {out_valid, busy, overflow}, 0);
    dones = '0;
    step(1);
  endtask

  initial begin
    int base;
    int n;
    randomize_vals();

    do_reset();
    run_ordered_frame();

    // Backpressure with enable gaps on row 0
    do_reset();
    randomize_vals();
    push_row(0);
    base      = nbeats;
    out_ready = 1'b0;
    dones[0]  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2) == 1;
      en        = (i % 7) != 5;
      step(1);
    end
    en        = 1'b1;
    out_ready = 1'b1;
    wait_empty("bp_drained", 50);
    step(2);
    chk("bp_beats", nbeats - base, 8);
    chk("bp_busy", busy, 0);

    // Row 3 arrives before rows 0..2
    do_reset();
    randomize_vals();
    for (int r = 0; r < 4; r++) push_row(r);
    dones[3] = 1'b1;
    step(4);
    chk("ooo_wait_valid", out_valid, 0);
    chk("ooo_wait_busy", busy, 1);
    for (int r = 0; r < 3; r++) begin
      dones[r] = 1'b1;
      step(1);
    end
    wait_empty("ooo_drained", 100);
    step(2);
    chk("ooo_end_state", {out_valid, busy, overflow}, 0);

    // Re-pulse of a pending row
    do_reset();
    randomize_vals();
    push_row(0);
    out_ready = 1'b0;
    dones[0]  = 1'b1;
    step(3);
    dones[0] = 1'b0;
    step(1);
    randomize_vals();
    dones[0] = 1'b1;
    step(2);
    chk("ovf_set", overflow, 1);
    out_ready = 1'b1;
    wait_empty("ovf_drained", 50);
    step(2);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_busy", busy, 0);

    // Reset after beat 5, then a clean frame
    do_reset();
    randomize_vals();
    push_row(0);
    base     = nbeats;
    dones[0] = 1'b1;
    n        = 0;
    while ((nbeats - base) < 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_beats", nbeats - base, 5);
    do_reset();
    run_ordered_frame();

    // Saturation corner values
    do_reset();
    for (int c = 0; c < COLS; c++) pe_val[0][c] = 36'(c * 3);
    pe_val[0][0] = 36'(40000);
    pe_val[0][1] = 36'(-40000);
    push_row(0);
    dones[0] = 1'b1;
    wait_empty("sat_drained", 50);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
